// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between instruction fetch (I, read-only) and data (D, read/write).
// Round-robin on contention; each transaction runs IDLE -> ACCESS x MEM_LATENCY -> RESP with a one-cycle done.
module mem_port_arbiter #(
  parameter int MEM_LATENCY = 2,
  parameter int CNT_W       = 4
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic            i_req,
  input  logic [31:0]     i_addr,
  output logic [0:3][7:0] i_rdata,
  output logic            i_done,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [31:0]     d_addr,
  input  logic [0:3][7:0] d_wdata,
  output logic [0:3][7:0] d_rdata,
  output logic            d_done,
  output logic [31:0]     mem_addr,
  output logic [0:3][7:0] mem_data_in,
  input  logic [0:3][7:0] mem_data_out,
  output logic            mem_write_en,
  output logic            busy,
  output logic            owner
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] counter_r;
  logic             last_r;
  logic             we_r;

  logic             grant_s;
  logic             grant_we_s;
  logic [31:0]      grant_addr_s;
  logic [0:3][7:0]  grant_wdata_s;

  // Grant selection: a lone requester wins, contention goes to whoever did not win last.
  always_comb begin
    grant_s       = 1'b0;
    grant_we_s    = 1'b0;
    grant_addr_s  = i_addr;
    grant_wdata_s = 32'h0000_0000;
    if (i_req && d_req) begin
      grant_s = ~last_r;
    end else if (d_req) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
    if (grant_s) begin
      grant_we_s    = d_we;
      grant_addr_s  = d_addr;
      grant_wdata_s = d_wdata;
    end else begin
      grant_we_s    = 1'b0;
      grant_addr_s  = i_addr;
      grant_wdata_s = 32'h0000_0000;
    end
  end

  // Transaction sequencer; every output is a register so the memory sees glitch-free strobes.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      state_r      <= IDLE;
      counter_r    <= {CNT_W{1'b0}};
      last_r       <= 1'b0;
      we_r         <= 1'b0;
      i_rdata      <= 32'h0000_0000;
      d_rdata      <= 32'h0000_0000;
      i_done       <= 1'b0;
      d_done       <= 1'b0;
      mem_addr     <= 32'h0000_0000;
      mem_data_in  <= 32'h0000_0000;
      mem_write_en <= 1'b0;
      busy         <= 1'b0;
      owner        <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (i_req || d_req) begin
            state_r      <= ACCESS;
            mem_addr     <= grant_addr_s;
            we_r         <= grant_we_s;
            mem_write_en <= grant_we_s;
            mem_data_in  <= grant_we_s ? grant_wdata_s : 32'h0000_0000;
            owner        <= grant_s;
            last_r       <= grant_s;
            counter_r    <= CNT_W'(MEM_LATENCY - 1);
            busy         <= 1'b1;
          end
        end
        ACCESS: begin
          if (counter_r == {CNT_W{1'b0}}) begin
            state_r      <= RESP;
            mem_write_en <= 1'b0;
            mem_data_in  <= 32'h0000_0000;
            if (owner) begin
              d_done <= 1'b1;
              if (!we_r) begin
                d_rdata <= mem_data_out;
              end
            end else begin
              i_done  <= 1'b1;
              i_rdata <= mem_data_out;
            end
          end else begin
            counter_r <= counter_r - CNT_W'(1);
          end
        end
        RESP: begin
          state_r <= IDLE;
          i_done  <= 1'b0;
          d_done  <= 1'b0;
          busy    <= 1'b0;
        end
        default: begin
          state_r      <= IDLE;
          i_done       <= 1'b0;
          d_done       <= 1'b0;
          mem_write_en <= 1'b0;
          busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule
